// File: rtl/memory_datapath.sv
// Memory card game datapath.
//
// Holds the 16-card board, the face-up and matched masks, both players'
// scores, the held first card, the mismatch pause counter and the per-turn
// seconds timer. A separate turn-control FSM drives the single-cycle command
// inputs and reads back the status outputs.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   board_load_i, board_i       load a new board (card k at bits [3k+2:3k]) and restart
//   cursor_i, btn_raw_i         player cursor and raw select pulse
//   select_*/auto_select_*      first/second card commands (manual or timed-out)
//   start_pause_i, end_turn_i   mismatch pause start, end of turn
//   extra_turn_i                same player continues, timer reloaded
//   restart_timer_i             timer reload only
//   btn_sel_o                   select pulse gated by card/game state
//   time_up_o, cards_match_o, pause_done_o, auto_pick1_valid_o,
//   auto_pick2_valid_o, match_happened_o
//                               status returned to the FSM
//   face_up_o, matched_o        per-card display masks
//   player_o, score0_o, score1_o, secs_left_o, game_over_o
//                               game status
module memory_datapath #(
    parameter int unsigned TURN_SECS    = 15,
    parameter int unsigned SEC_CYCLES   = 50_000_000,
    parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        board_load_i,
    input  logic [47:0] board_i,
    input  logic [3:0]  cursor_i,
    input  logic        btn_raw_i,
    input  logic        select_first_card_i,
    input  logic        select_second_card_i,
    input  logic        auto_select_first_i,
    input  logic        auto_select_second_i,
    input  logic        start_pause_i,
    input  logic        end_turn_i,
    input  logic        extra_turn_i,
    input  logic        restart_timer_i,
    output logic        btn_sel_o,
    output logic        time_up_o,
    output logic        cards_match_o,
    output logic        pause_done_o,
    output logic        auto_pick1_valid_o,
    output logic        auto_pick2_valid_o,
    output logic        match_happened_o,
    output logic [15:0] face_up_o,
    output logic [15:0] matched_o,
    output logic        player_o,
    output logic [3:0]  score0_o,
    output logic [3:0]  score1_o,
    output logic [3:0]  secs_left_o,
    output logic        game_over_o
);

    localparam logic [3:0]  TurnSecs  = 4'(TURN_SECS);
    localparam logic [31:0] SecLast   = 32'(SEC_CYCLES - 1);
    localparam logic [31:0] PauseLoad = 32'(PAUSE_CYCLES - 1);

    logic [47:0] board_q, board_d;
    logic [15:0] face_up_q, face_up_d;
    logic [15:0] matched_q, matched_d;
    logic [3:0]  score0_q, score0_d;
    logic [3:0]  score1_q, score1_d;
    logic        player_q, player_d;
    logic [3:0]  first_idx_q, first_idx_d;
    logic        first_valid_q, first_valid_d;
    logic        pausing_q, pausing_d;
    logic [31:0] pause_cnt_q, pause_cnt_d;
    logic [3:0]  secs_q, secs_d;
    logic [31:0] presc_q, presc_d;
    logic        match_happened_q, match_happened_d;

    logic [2:0]  sym [16];
    logic [3:0]  pick1, pick2, cand2;
    logic        pick1_found, pick2_found;
    logic        selectable;
    logic        game_over;
    logic        time_up;
    logic        cards_match;
    logic        reload;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sym[k] = board_q[3*k +: 3];
        end
    end

    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        pick1       = '0;
        pick1_found = 1'b0;
        pick2       = '0;
        pick2_found = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (!matched_q[k]) begin
                pick1       = 4'(k);
                pick1_found = 1'b1;
                if (4'(k) != first_idx_q) begin
                    pick2       = 4'(k);
                    pick2_found = 1'b1;
                end
            end
        end
    end

    assign game_over   = &matched_q;
    assign time_up     = (secs_q == 4'd0) && !pausing_q && !game_over;
    assign cand2       = time_up ? pick2 : cursor_i;
    assign cards_match = first_valid_q && (cand2 != first_idx_q)
                         && (sym[cand2] == sym[first_idx_q]);
    assign selectable  = !matched_q[cursor_i] && !(first_valid_q && (cursor_i == first_idx_q));

    always_comb begin
        board_d          = board_q;
        face_up_d        = face_up_q;
        matched_d        = matched_q;
        score0_d         = score0_q;
        score1_d         = score1_q;
        player_d         = player_q;
        first_idx_d      = first_idx_q;
        first_valid_d    = first_valid_q;
        pausing_d        = pausing_q;
        pause_cnt_d      = pause_cnt_q;
        secs_d           = secs_q;
        presc_d          = presc_q;
        match_happened_d = 1'b0;
        reload           = 1'b0;

        // Seconds prescaler; frozen during a pause and once the turn has expired.
        if (!pausing_q && (secs_q != 4'd0)) begin
            if (presc_q == SecLast) begin
                presc_d = '0;
                secs_d  = secs_q - 4'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end

        if (pausing_q && (pause_cnt_q != '0)) begin
            pause_cnt_d = pause_cnt_q - 32'd1;
        end

        if (board_load_i) begin
            board_d       = board_i;
            face_up_d     = '0;
            matched_d     = '0;
            score0_d      = '0;
            score1_d      = '0;
            player_d      = 1'b0;
            first_valid_d = 1'b0;
            pausing_d     = 1'b0;
            pause_cnt_d   = '0;
            reload        = 1'b1;
        end else begin
            if (!game_over) begin
                if (select_first_card_i) begin
                    first_idx_d          = cursor_i;
                    first_valid_d        = 1'b1;
                    face_up_d[cursor_i]  = 1'b1;
                end else if (auto_select_first_i) begin
                    first_idx_d          = pick1;
                    first_valid_d        = 1'b1;
                    face_up_d[pick1]     = 1'b1;
                end

                if (select_second_card_i || auto_select_second_i) begin
                    if (cards_match) begin
                        matched_d[cand2]       = 1'b1;
                        matched_d[first_idx_q] = 1'b1;
                        face_up_d[cand2]       = 1'b0;
                        face_up_d[first_idx_q] = 1'b0;
                        first_valid_d          = 1'b0;
                        match_happened_d       = 1'b1;
                        if (!player_q) begin
                            if (score0_q != 4'hF) score0_d = score0_q + 4'd1;
                        end else begin
                            if (score1_q != 4'hF) score1_d = score1_q + 4'd1;
                        end
                    end else begin
                        face_up_d[cand2] = 1'b1;
                    end
                end
            end

            if (start_pause_i) begin
                pausing_d   = 1'b1;
                pause_cnt_d = PauseLoad;
            end

            if (end_turn_i) begin
                pausing_d     = 1'b0;
                face_up_d     = '0;
                first_valid_d = 1'b0;
                player_d      = ~player_q;
                reload        = 1'b1;
            end

            if (extra_turn_i || restart_timer_i) begin
                reload = 1'b1;
            end
        end

        // Reload wins over a same-cycle prescaler decrement.
        if (reload) begin
            secs_d  = TurnSecs;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q          <= '0;
            face_up_q        <= '0;
            matched_q        <= '0;
            score0_q         <= '0;
            score1_q         <= '0;
            player_q         <= 1'b0;
            first_idx_q      <= '0;
            first_valid_q    <= 1'b0;
            pausing_q        <= 1'b0;
            pause_cnt_q      <= '0;
            secs_q           <= TurnSecs;
            presc_q          <= '0;
            match_happened_q <= 1'b0;
        end else begin
            board_q          <= board_d;
            face_up_q        <= face_up_d;
            matched_q        <= matched_d;
            score0_q         <= score0_d;
            score1_q         <= score1_d;
            player_q         <= player_d;
            first_idx_q      <= first_idx_d;
            first_valid_q    <= first_valid_d;
            pausing_q        <= pausing_d;
            pause_cnt_q      <= pause_cnt_d;
            secs_q           <= secs_d;
            presc_q          <= presc_d;
            match_happened_q <= match_happened_d;
        end
    end

    assign btn_sel_o          = btn_raw_i && selectable && !pausing_q && !game_over;
    assign time_up_o          = time_up;
    assign cards_match_o      = cards_match;
    assign pause_done_o       = pausing_q && (pause_cnt_q == '0);
    assign auto_pick1_valid_o = pick1_found;
    assign auto_pick2_valid_o = first_valid_q && pick2_found;
    assign match_happened_o   = match_happened_q;
    assign face_up_o          = face_up_q;
    assign matched_o          = matched_q;
    assign player_o           = player_q;
    assign score0_o           = score0_q;
    assign score1_o           = score1_q;
    assign secs_left_o        = secs_q;
    assign game_over_o        = game_over;

endmodule

// File: tb/tb_memory_datapath.sv
// Directed bench for memory_datapath with a small expectation scoreboard.
module tb_memory_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        board_load_i = 1'b0;
    logic [47:0] board_i = '0;
    logic [3:0]  cursor_i = '0;
    logic        btn_raw_i = 1'b0;
    logic        select_first_card_i = 1'b0;
    logic        select_second_card_i = 1'b0;
    logic        auto_select_first_i = 1'b0;
    logic        auto_select_second_i = 1'b0;
    logic        start_pause_i = 1'b0;
    logic        end_turn_i = 1'b0;
    logic        extra_turn_i = 1'b0;
    logic        restart_timer_i = 1'b0;
    logic        btn_sel_o, time_up_o, cards_match_o, pause_done_o;
    logic        auto_pick1_valid_o, auto_pick2_valid_o, match_happened_o;
    logic [15:0] face_up_o, matched_o;
    logic        player_o, game_over_o;
    logic [3:0]  score0_o, score1_o, secs_left_o;

    memory_datapath #(
        .TURN_SECS   (3),
        .SEC_CYCLES  (4),
        .PAUSE_CYCLES(3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .board_load_i        (board_load_i),
        .board_i             (board_i),
        .cursor_i            (cursor_i),
        .btn_raw_i           (btn_raw_i),
        .select_first_card_i (select_first_card_i),
        .select_second_card_i(select_second_card_i),
        .auto_select_first_i (auto_select_first_i),
        .auto_select_second_i(auto_select_second_i),
        .start_pause_i       (start_pause_i),
        .end_turn_i          (end_turn_i),
        .extra_turn_i        (extra_turn_i),
        .restart_timer_i     (restart_timer_i),
        .btn_sel_o           (btn_sel_o),
        .time_up_o           (time_up_o),
        .cards_match_o       (cards_match_o),
        .pause_done_o        (pause_done_o),
        .auto_pick1_valid_o  (auto_pick1_valid_o),
        .auto_pick2_valid_o  (auto_pick2_valid_o),
        .match_happened_o    (match_happened_o),
        .face_up_o           (face_up_o),
        .matched_o           (matched_o),
        .player_o            (player_o),
        .score0_o            (score0_o),
        .score1_o            (score1_o),
        .secs_left_o         (secs_left_o),
        .game_over_o         (game_over_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [47:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [47:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [47:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow: observed=%0h required=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        board_load_i         = 1'b0;
        btn_raw_i            = 1'b0;
        select_first_card_i  = 1'b0;
        select_second_card_i = 1'b0;
        auto_select_first_i  = 1'b0;
        auto_select_second_i = 1'b0;
        start_pause_i        = 1'b0;
        end_turn_i           = 1'b0;
        extra_turn_i         = 1'b0;
        restart_timer_i      = 1'b0;
    endtask

    logic [2:0]  psym [8];
    logic [47:0] board_v;

    initial begin
        // Pair p is cards 2p and 2p+1.
        psym = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6, 3'd7};
        for (int k = 0; k < 16; k++) board_v[3*k +: 3] = psym[k/2];

        // Reset values while rst is held.
        #12;
        push("rst_secs", 48'd3);     compare(48'(secs_left_o));
        push("rst_face", 48'd0);     compare(48'(face_up_o));
        push("rst_matched", 48'd0);  compare(48'(matched_o));
        push("rst_player", 48'd0);   compare(48'(player_o));
        push("rst_score0", 48'd0);   compare(48'(score0_o));
        push("rst_mh", 48'd0);       compare(48'(match_happened_o));
        push("rst_pdone", 48'd0);    compare(48'(pause_done_o));
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Load board.
        board_i = board_v; board_load_i = 1'b1;
        push("load_secs", 48'd3);
        push("load_face", 48'd0);
        cyc(); idle();
        compare(48'(secs_left_o));
        compare(48'(face_up_o));

        // Select card 0 as first.
        cursor_i = 4'd0; btn_raw_i = 1'b1; select_first_card_i = 1'b1;
        push("btn_sel_ok", 48'd1);
        #1 compare(48'(btn_sel_o));
        push("first_face", 48'h0001);
        cyc(); idle();
        compare(48'(face_up_o));

        // Held first card is not selectable.
        btn_raw_i = 1'b1; cursor_i = 4'd0;
        push("btn_sel_held", 48'd0);
        #1 compare(48'(btn_sel_o));
        btn_raw_i = 1'b0;

        // Second card 1 matches card 0.
        cursor_i = 4'd1;
        push("match_comb", 48'd1);
        #1 compare(48'(cards_match_o));
        select_second_card_i = 1'b1;
        push("mh_pulse", 48'd1);
        push("matched_01", 48'h0003);
        push("score0_1", 48'd1);
        push("face_clr", 48'd0);
        cyc(); idle();
        compare(48'(match_happened_o));
        compare(48'(matched_o));
        compare(48'(score0_o));
        compare(48'(face_up_o));
        push("mh_one_cycle", 48'd0);
        cyc();
        compare(48'(match_happened_o));

        // Matched card is not selectable.
        btn_raw_i = 1'b1; cursor_i = 4'd0;
        push("btn_sel_matched", 48'd0);
        #1 compare(48'(btn_sel_o));
        btn_raw_i = 1'b0;

        // Mismatch: cards 2 (sym 1) and 4 (sym 2).
        cursor_i = 4'd2; select_first_card_i = 1'b1;
        cyc(); idle();
        cursor_i = 4'd4;
        push("nomatch_comb", 48'd0);
        #1 compare(48'(cards_match_o));
        select_second_card_i = 1'b1;
        push("mismatch_face", 48'h0014);
        cyc(); idle();
        compare(48'(face_up_o));

        // Pause: done exactly three cycles after the command is driven.
        start_pause_i = 1'b1;
        push("pause_c1", 48'd0);
        cyc(); idle();
        compare(48'(pause_done_o));
        push("pause_c2", 48'd0);
        cyc();
        compare(48'(pause_done_o));
        push("pause_c3", 48'd1);
        cyc();
        compare(48'(pause_done_o));
        push("pause_hold", 48'd1);
        cyc();
        compare(48'(pause_done_o));

        // End turn.
        end_turn_i = 1'b1;
        push("et_face", 48'd0);
        push("et_player", 48'd1);
        push("et_secs", 48'd3);
        push("et_pdone", 48'd0);
        cyc(); idle();
        compare(48'(face_up_o));
        compare(48'(player_o));
        compare(48'(secs_left_o));
        compare(48'(pause_done_o));

        // Idle 12 cycles: 3 -> 2 -> 1 -> 0.
        for (int c = 1; c <= 12; c++) begin
            if (c == 3)  push("secs_c3", 48'd3);
            if (c == 4)  push("secs_c4", 48'd2);
            if (c == 8)  push("secs_c8", 48'd1);
            if (c == 12) push("secs_c12", 48'd0);
            cyc();
            if (c == 3 || c == 4 || c == 8 || c == 12) compare(48'(secs_left_o));
        end
        push("time_up", 48'd1);
        compare(48'(time_up_o));

        // Timed-out auto picks: 2 then 3 match, then 4 is picked.
        push("ap1_valid", 48'd1);
        compare(48'(auto_pick1_valid_o));
        auto_select_first_i = 1'b1;
        push("auto_first_face", 48'h0004);
        cyc(); idle();
        compare(48'(face_up_o));
        push("auto_match_comb", 48'd1);
        #1 compare(48'(cards_match_o));
        auto_select_second_i = 1'b1;
        push("auto_matched", 48'h000F);
        push("score1_1", 48'd1);
        cyc(); idle();
        compare(48'(matched_o));
        compare(48'(score1_o));
        auto_select_first_i = 1'b1;
        push("auto_pick4_face", 48'h0010);
        push("ap2_valid", 48'd1);
        cyc(); idle();
        compare(48'(face_up_o));
        compare(48'(auto_pick2_valid_o));

        // Restart on the prescaler rollover edge.
        end_turn_i = 1'b1;
        cyc(); idle();
        cyc(); cyc(); cyc();
        restart_timer_i = 1'b1;
        push("restart_rollover", 48'd3);
        cyc(); idle();
        compare(48'(secs_left_o));
        cyc(); cyc(); cyc();
        push("restart_presc_clr", 48'd3);
        compare(48'(secs_left_o));
        push("restart_next_dec", 48'd2);
        cyc();
        compare(48'(secs_left_o));

        // Full game to game over.
        board_i = board_v; board_load_i = 1'b1;
        push("reload_score1", 48'd0);
        cyc(); idle();
        compare(48'(score1_o));
        for (int p = 0; p < 8; p++) begin
            restart_timer_i = 1'b1; select_first_card_i = 1'b1; cursor_i = 4'(2*p);
            cyc(); idle();
            select_second_card_i = 1'b1; cursor_i = 4'(2*p + 1);
            cyc(); idle();
        end
        push("go_matched", 48'hFFFF);
        push("go_flag", 48'd1);
        push("go_score0", 48'd8);
        compare(48'(matched_o));
        compare(48'(game_over_o));
        compare(48'(score0_o));
        btn_raw_i = 1'b1; cursor_i = 4'd5;
        push("go_btn_sel", 48'd0);
        #1 compare(48'(btn_sel_o));
        btn_raw_i = 1'b0;
        select_first_card_i = 1'b1; cursor_i = 4'd3;
        push("go_ignore_cmd", 48'd0);
        cyc(); idle();
        compare(48'(face_up_o));
        for (int c = 0; c < 12; c++) cyc();
        push("go_secs0", 48'd0);
        push("go_no_timeup", 48'd0);
        compare(48'(secs_left_o));
        compare(48'(time_up_o));

        // board_load wins over a same-cycle card command.
        board_i = board_v; board_load_i = 1'b1; select_first_card_i = 1'b1; cursor_i = 4'd7;
        push("bl_prio_face", 48'd0);
        push("bl_go_clr", 48'd0);
        push("bl_score0", 48'd0);
        cyc(); idle();
        compare(48'(face_up_o));
        compare(48'(game_over_o));
        compare(48'(score0_o));

        // Reset mid-pause.
        cursor_i = 4'd0; select_first_card_i = 1'b1;
        cyc(); idle();
        cursor_i = 4'd2; select_second_card_i = 1'b1;
        cyc(); idle();
        start_pause_i = 1'b1;
        cyc(); idle();
        #2 rst = 1'b1;
        #1;
        push("rstp_face", 48'd0);
        push("rstp_secs", 48'd3);
        push("rstp_player", 48'd0);
        compare(48'(face_up_o));
        compare(48'(secs_left_o));
        compare(48'(player_o));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            push("rstp_no_pdone", 48'd0);
            cyc();
            compare(48'(pause_done_o));
        end
        push("rstp_no_mh", 48'd0);
        compare(48'(match_happened_o));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_datapath.md
MEMORY_DATAPATH -- requirements
Module: memory_datapath

Interface
REQ-001 The module SHALL have parameter TURN_SECS, default 15, giving the turn length in seconds (1..15).
REQ-002 The module SHALL have parameter SEC_CYCLES, default 50_000_000, giving the clock cycles per second.
REQ-003 The module SHALL have parameter PAUSE_CYCLES, default 50_000_000, giving the mismatch display time in cycles.
REQ-004 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port board_load_i, input, 1: one-cycle pulse that loads board_i and starts a new game.
REQ-007 Port board_i, input, 48: 16 card symbols, 3 bits each; card k SHALL occupy bits [3k+2:3k].
REQ-008 Port cursor_i, input, 4: card index under the player cursor.
REQ-009 Port btn_raw_i, input, 1: debounced select pulse from the player.
REQ-010 Ports select_first_card_i, select_second_card_i, auto_select_first_i, auto_select_second_i, start_pause_i, end_turn_i, extra_turn_i, restart_timer_i, input, 1 each: single-cycle commands from the turn-control FSM.
REQ-011 Port btn_sel_o, output, 1: gated select pulse sent to the FSM.
REQ-012 Ports time_up_o, cards_match_o, pause_done_o, auto_pick1_valid_o, auto_pick2_valid_o, match_happened_o, output, 1 each: status returned to the FSM.
REQ-013 Ports face_up_o and matched_o, output, 16 each: per-card display masks.
REQ-014 Ports player_o (output, 1), score0_o and score1_o (output, 4 each), secs_left_o (output, 4) and game_over_o (output, 1): game status.

Function
REQ-015 A card SHALL be selectable when it is not matched and is not the held first card. btn_sel_o SHALL equal btn_raw_i AND selectable(cursor_i) AND NOT pausing AND NOT game_over_o.
REQ-016 auto_pick1 SHALL be the lowest-index unmatched card; auto_pick1_valid_o SHALL be high when such a card exists.
REQ-017 auto_pick2 SHALL be the lowest-index card that is unmatched and differs from first_idx; auto_pick2_valid_o SHALL be high when first_valid is set and such a card exists.
REQ-018 The second-card candidate cand2 SHALL be auto_pick2 when time_up_o is high, and cursor_i otherwise.
REQ-019 cards_match_o SHALL be combinational: first_valid AND cand2 differs from first_idx AND symbol[cand2] equals symbol[first_idx].
REQ-020 On select_first_card_i the block SHALL set first_idx to cursor_i, set first_valid, and set face_up[cursor_i]. On auto_select_first_i it SHALL do the same using auto_pick1.
REQ-021 On a second-card command (select_second_card_i or auto_select_second_i) with cards_match_o high, the block SHALL set matched for both cards and clear their face_up bits.
REQ-022 In that same match case, the block SHALL increment the current player's score (saturating at 15), clear first_valid, and pulse match_happened_o high for exactly the next cycle.
REQ-023 On a second-card command with no match, the block SHALL set face_up[cand2] and keep both cards face up until end_turn_i.
REQ-024 start_pause_i SHALL set pausing and load the pause counter with PAUSE_CYCLES-1. While pausing the counter SHALL decrement and stop at 0.
REQ-025 pause_done_o SHALL equal pausing AND (pause counter == 0).
REQ-026 end_turn_i SHALL clear pausing, clear all face_up bits, clear first_valid, toggle player_o, and reload the turn timer.
REQ-027 extra_turn_i SHALL leave player_o unchanged.
REQ-028 The timer SHALL reload secs_left to TURN_SECS and clear the second prescaler on restart_timer_i, extra_turn_i, end_turn_i or board_load_i.
REQ-029 Otherwise, while not pausing and secs_left > 0, the timer SHALL decrement secs_left once every SEC_CYCLES cycles. It SHALL freeze during a pause.
REQ-030 time_up_o SHALL equal (secs_left == 0) AND NOT pausing AND NOT game_over_o.
REQ-031 game_over_o SHALL be high when matched_o is all ones. From then on, all card commands SHALL be ignored until board_load_i.
REQ-032 A timer reload SHALL take priority over a prescaler decrement in the same cycle.
REQ-033 board_load_i SHALL take priority over every FSM command in the same cycle.
REQ-034 board_load_i SHALL clear the masks, scores, first_valid and pausing, and SHALL set player_o to 0.

Reset
REQ-035 While rst is high, all registers SHALL be cleared asynchronously: board symbols = 0, masks = 0, scores = 0, player_o = 0, first_valid = 0, pausing = 0, match_happened_o = 0.
REQ-036 While rst is high, secs_left_o SHALL equal TURN_SECS.
REQ-037 Reset asserted mid-pause or mid-turn SHALL abandon that operation with no residual pulse after rst is released.

Verification (SEC_CYCLES=4, PAUSE_CYCLES=3, TURN_SECS=3)
REQ-038 Board with cards 0 and 1 symbol 5. Select card 0 then card 1 -> cards_match_o=1; next cycle match_happened_o=1, matched_o=16'h0003, score0_o=1.
REQ-039 Mismatch on cards 0 and 2, then start_pause_i -> pause_done_o high exactly 3 cycles later; end_turn_i -> face_up_o=0, player_o=1, secs_left_o=3.
REQ-040 No commands for 12 cycles -> secs_left_o steps 3,2,1,0 and time_up_o=1; matched cards 0..3 -> auto_pick1 selects card 4.
REQ-041 btn_raw_i on an already matched card or on the held first card -> btn_sel_o=0.
REQ-042 restart_timer_i in the same cycle as a prescaler rollover -> secs_left_o=3, no decrement.
REQ-043 rst pulsed during a pause -> pause_done_o never asserts; all outputs at their reset values.
